// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer that decouples in_ready from out_ready.
module pipe_stage_skid #(
    parameter int CTRL_W      = 12,
    parameter int DATA_W      = 128,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 state_s;
    logic [CTRL_W-1:0]      main_ctrl_r;
    logic [DATA_W-1:0]      main_data_r;
    logic [CTRL_W-1:0]      skid_ctrl_r;
    logic [DATA_W-1:0]      skid_data_r;
    logic [STALL_CNT_W-1:0] stall_r;
    logic                   load_main_s;
    logic                   skid_to_main_s;
    logic                   load_skid_s;
    logic                   in_fire_s;
    logic                   out_fire_s;

    // With the skid buffer in_ready comes from state only; without it, ready passes through.
    assign out_valid  = (state_r != ST_EMPTY);
    assign in_ready   = (SKID != 0) ? (state_r != ST_TWO) : (~out_valid | out_ready);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Next-state and load-enable decode; flush discards everything, including an in_fire.
    always_comb begin
        state_s        = state_r;
        load_main_s    = 1'b0;
        skid_to_main_s = 1'b0;
        load_skid_s    = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_s     = ST_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        load_main_s = 1'b1;
                    end else if (in_fire_s) begin
                        if (SKID != 0) begin
                            state_s     = ST_TWO;
                            load_skid_s = 1'b1;
                        end else begin
                            load_main_s = 1'b1;
                        end
                    end else if (out_fire_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_s        = ST_ONE;
                        skid_to_main_s = 1'b1;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Main and skid entry registers; data is left untouched on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_ctrl_r <= in_ctrl;
                main_data_r <= in_data;
            end else if (skid_to_main_s) begin
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
            end
            if (load_skid_s) begin
                skid_ctrl_r <= in_ctrl;
                skid_data_r <= in_data;
            end
        end
    end

    // Saturating count of cycles where the head is held by downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= {STALL_CNT_W{1'b0}};
        end else if (out_valid && !out_ready && (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + STALL_ONE;
        end
    end

    // Occupancy decode from state.
    always_comb begin
        occupancy = 2'd0;
        case (state_r)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_TWO:   occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    assign out_ctrl     = out_valid ? main_ctrl_r : {CTRL_W{1'b0}};
    assign out_data     = main_data_r;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 instance (16-bit stall counter) and a
// SKID=0 instance (4-bit stall counter), each checked against a queue model.
module tb_pipe_stage_skid;

    localparam int CW = 12;
    localparam int DW = 128;

    logic          clk;
    logic          reset;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          out_ready [2];
    logic [CW-1:0] in_ctrl   [2];
    logic [DW-1:0] in_data   [2];
    logic          in_ready  [2];
    logic          out_valid [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic [1:0]    occupancy [2];
    logic [3:0]    stall0;
    logic [15:0]   stall1;

    // Reference model: an up-to-two-entry FIFO, a stall count and the last head data.
    logic [CW-1:0] mq_c  [2][2];
    logic [DW-1:0] mq_d  [2][2];
    int            mcnt  [2];
    logic [15:0]   mstall[2];
    logic [DW-1:0] mlast [2];
    bit            model_ok;
    int            total;
    int            bad;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .STALL_CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
        .occupancy(occupancy[0]), .stall_cycles(stall0)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
        .occupancy(occupancy[1]), .stall_cycles(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Compare one DUT against the model, then advance the model across the coming edge.
    task automatic model_cycle(input int d);
        logic        exp_rdy;
        logic [15:0] smax;
        logic [15:0] st_act;
        smax    = (d == 1) ? 16'hFFFF : 16'h000F;
        st_act  = (d == 1) ? stall1 : {12'd0, stall0};
        exp_rdy = (d == 1) ? (mcnt[d] < 2) : (mcnt[d] == 0 || out_ready[d]);
        if (model_ok) begin
            chk("out_valid", d, DW'(out_valid[d]), DW'(mcnt[d] != 0));
            chk("out_ctrl", d, DW'(out_ctrl[d]), DW'((mcnt[d] != 0) ? mq_c[d][0] : 12'd0));
            chk("out_data", d, out_data[d], (mcnt[d] != 0) ? mq_d[d][0] : mlast[d]);
            chk("occupancy", d, DW'(occupancy[d]), DW'(mcnt[d]));
            chk("in_ready", d, DW'(in_ready[d]), DW'(exp_rdy));
            chk("stall_cycles", d, DW'(st_act), DW'(mstall[d]));
        end
        if (reset) begin
            mcnt[d]   = 0;
            mstall[d] = 16'd0;
            mlast[d]  = {DW{1'b0}};
        end else begin
            if (mcnt[d] != 0 && !out_ready[d] && mstall[d] != smax) mstall[d] = mstall[d] + 16'd1;
            if (flush[d]) begin
                mcnt[d] = 0;
            end else begin
                if (mcnt[d] != 0 && out_ready[d]) begin
                    mq_c[d][0] = mq_c[d][1];
                    mq_d[d][0] = mq_d[d][1];
                    mcnt[d]    = mcnt[d] - 1;
                end
                if (in_valid[d] && exp_rdy) begin
                    mq_c[d][mcnt[d]] = in_ctrl[d];
                    mq_d[d][mcnt[d]] = in_data[d];
                    mcnt[d]          = mcnt[d] + 1;
                end
            end
            if (mcnt[d] != 0) mlast[d] = mq_d[d][0];
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0);
        model_cycle(1);
        if (reset) model_ok = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [CW-1:0] c, input logic [DW-1:0] dd,
                         input logic rdy, input logic fl);
        in_valid[d]  = v;
        in_ctrl[d]   = c;
        in_data[d]   = dd;
        out_ready[d] = rdy;
        flush[d]     = fl;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        model_ok = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mcnt[d]   = 0;
            mstall[d] = 16'd0;
            mlast[d]  = {DW{1'b0}};
        end

        // Reset for two cycles with in_valid high.
        reset = 1'b1;
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 12'h5A5, {4{32'hDEADBEEF}}, 1'b0, 1'b0);
        repeat (2) cyc();
        reset = 1'b0;

        // Streaming with out_ready held high.
        for (int i = 1; i <= 5; i++) begin
            for (int d = 0; d < 2; d++) drive(d, 1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
            cyc();
        end
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 12'h0, 128'h0, 1'b1, 1'b0);
        repeat (2) cyc();

        // Back-pressure: A then B with out_ready low, then two more stalled cycles.
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 12'h00A, 128'hA, 1'b0, 1'b0);
        cyc();
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 12'h00B, 128'hB, 1'b0, 1'b0);
        cyc();
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 12'h0, 128'h0, 1'b0, 1'b0);
        repeat (2) cyc();
        chk("bp_stall", 1, DW'(stall1), DW'(16'd3));
        chk("bp_stall", 0, DW'(stall0), DW'(4'd3));
        chk("bp_occupancy", 1, DW'(occupancy[1]), DW'(2'd2));
        chk("bp_in_ready", 1, DW'(in_ready[1]), DW'(1'b0));
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 12'h0, 128'h0, 1'b1, 1'b0);
        repeat (3) cyc();

        // Flush while full, with C offered in the same cycle.
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 12'h00D, 128'hDD, 1'b0, 1'b0);
        cyc();
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 12'h00E, 128'hEE, 1'b0, 1'b0);
        cyc();
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 12'h00C, 128'hCC, 1'b0, 1'b1);
        cyc();
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 12'h0, 128'h0, 1'b1, 1'b0);
            chk("flush_valid", d, DW'(out_valid[d]), DW'(1'b0));
            chk("flush_ctrl", d, DW'(out_ctrl[d]), DW'(12'h0));
            chk("flush_occupancy", d, DW'(occupancy[d]), DW'(2'd0));
            chk("flush_data", d, out_data[d], 128'hDD);
        end
        repeat (3) cyc();

        // SKID=0: in_ready follows out_ready within the cycle, then replace-in-place.
        drive(0, 1'b1, 12'h00F, 128'hFF, 1'b0, 1'b0);
        cyc();
        drive(0, 1'b0, 12'h0, 128'h0, 1'b0, 1'b0);
        #1 chk("comb_ready_lo", 0, DW'(in_ready[0]), DW'(1'b0));
        out_ready[0] = 1'b1;
        #1 chk("comb_ready_hi", 0, DW'(in_ready[0]), DW'(1'b1));
        out_ready[0] = 1'b0;
        #1 chk("comb_ready_lo2", 0, DW'(in_ready[0]), DW'(1'b0));
        drive(0, 1'b1, 12'h011, 128'h111, 1'b1, 1'b0);
        cyc();
        chk("replace_ctrl", 0, DW'(out_ctrl[0]), DW'(12'h011));
        chk("replace_data", 0, out_data[0], 128'h111);
        chk("replace_occupancy", 0, DW'(occupancy[0]), DW'(2'd1));

        // Saturation of the 4-bit counter, then cleared by reset.
        drive(0, 1'b0, 12'h0, 128'h0, 1'b0, 1'b0);
        repeat (20) cyc();
        chk("stall_sat", 0, DW'(stall0), DW'(4'hF));
        reset = 1'b1;
        cyc();
        chk("stall_reset", 0, DW'(stall0), DW'(4'h0));
        chk("stall_reset", 1, DW'(stall1), DW'(16'h0));
        reset = 1'b0;

        // Randomised traffic with occasional flush and reset.
        repeat (3000) begin
            for (int d = 0; d < 2; d++)
                drive(d, ($urandom % 10) < 7, CW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                      ($urandom % 10) < 6, ($urandom % 30) == 0);
            reset = (($urandom % 500) == 0);
            cyc();
        end
        reset = 1'b0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 12'h0, 128'h0, 1'b1, 1'b0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that generalises the fixed-field inter-stage registers of the MIPS pipeline. It carries a control bundle and a data bundle across a valid/ready boundary. It adds stall back-pressure, flush-to-bubble, and an optional two-entry skid buffer that cuts the combinational ready path. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces per-stage hand-written registers.

## Interface
Parameters:
- CTRL_W, 12: width of the control bundle (RegWrite, MemRead, ALUOp, ...); forced to zero on a bubble.
- DATA_W, 128: width of the data bundle (PC, operands, immediate, register indices); never zeroed by a flush.
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single-entry register with a combinational ready path.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high; has priority over everything.
- flush, in, 1: synchronous squash of all held entries.
- in_valid, in, 1: upstream entry valid.
- in_ready, out, 1: stage can accept an entry.
- in_ctrl, in, CTRL_W: upstream control bundle.
- in_data, in, DATA_W: upstream data bundle.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: downstream accepts the head entry.
- out_ctrl, out, CTRL_W: head control bundle; all zeros whenever out_valid=0.
- out_data, out, DATA_W: head data bundle.
- occupancy, out, 2: number of held entries (0..2).
- stall_cycles, out, STALL_CNT_W: saturating count of cycles with out_valid & !out_ready.

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States (SKID=1):
  - EMPTY: occupancy 0.
  - ONE: main register full.
  - TWO: main and skid registers full.
- in_ready (SKID=1) = (state != TWO). It depends only on registered state and has no path from out_ready.
- Transitions (SKID=1):
  - EMPTY, in_fire: go to ONE; main <= in.
  - ONE, in_fire & !out_fire: go to TWO; skid <= in.
  - ONE, out_fire & !in_fire: go to EMPTY.
  - ONE, in_fire & out_fire: stay in ONE; main <= in.
  - TWO, out_fire: go to ONE; main <= skid. No in_fire is possible in TWO.
  - Otherwise hold.
- Ordering is strict FIFO. The skid entry is never presented before the main entry.
- SKID=0:
  - States are EMPTY and ONE only.
  - in_ready = !out_valid | out_ready.
  - An in_fire loads main; an out_fire without in_fire goes to EMPTY.
- flush=1:
  - Next state is EMPTY, so out_valid=0 and out_ctrl=0 the following cycle.
  - Any in_fire in the same cycle is accepted and dropped.
  - out_data keeps its last value.
  - The stall counter is unaffected.
- reset=1:
  - Next state is EMPTY.
  - out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides flush and any in-flight handshake; held entries are lost.
- stall_cycles:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at all-ones and does not wrap.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in TWO.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is on out_* after edge N, with no bubble when out_ready stays high.
- Throughput is one entry per cycle in both SKID modes while out_ready=1.
- SKID=1: in_ready drops one cycle after the skid buffer fills. The entry accepted in that cycle is absorbed by the skid register.
- out_ready and flush may change every cycle. flush and reset take effect at the next edge.
- Outputs come directly from registers. out_ctrl is gated by the registered valid.

## Test plan
- Reset: apply reset for 2 cycles with in_valid=1.
  - After reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, stall_cycles=0.
- Streaming: hold out_ready=1 and push ctrl=0x001..0x005 with data=1..5.
  - Each appears on out_* exactly 1 cycle later, in order.
  - occupancy stays 1 throughout.
- Back-pressure (SKID=1): push A then B with out_ready=0.
  - occupancy becomes 2 and in_ready=0.
  - out_ready held low for 3 cycles gives stall_cycles=3.
  - Raising out_ready yields A, then B, then out_valid=0. No loss or duplication.
- Flush: flush in state TWO together with in_valid=1 carrying C.
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0, out_data unchanged.
  - C is never output.
- SKID=0: with out_valid=1, toggling out_ready toggles in_ready in the same cycle.
  - Simultaneous in_fire and out_fire replace the head with the new entry.
- Saturation: with STALL_CNT_W=4, hold a stall for 20 cycles.
  - stall_cycles stops at 15.
  - Reset clears it to 0.
